// File: rtl/food_spawner.sv
// Food placement engine: samples random candidates, checks them against the
// legal play area and the snake body, and commits the first free one.
module food_spawner #(
    parameter int MAX_TRIES   = 8,
    parameter int ACK_TIMEOUT = 15,
    parameter int X_MIN       = 20,
    parameter int X_MAX       = 620,
    parameter int Y_MIN       = 20,
    parameter int Y_MAX       = 460
) (
    input  logic       VGAclk,
    input  logic       reset,
    input  logic       spawn_req,
    input  logic [9:0] rX,
    input  logic [9:0] rY,
    output logic       occ_query,
    output logic [9:0] occ_qx,
    output logic [9:0] occ_qy,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [9:0] foodX,
    output logic [9:0] foodY,
    output logic       food_valid,
    output logic       busy,
    output logic       fail
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        QUERY  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [9:0] X_LO     = 10'(X_MIN);
    localparam logic [9:0] X_HI     = 10'(X_MAX);
    localparam logic [9:0] Y_LO     = 10'(Y_MIN);
    localparam logic [9:0] Y_HI     = 10'(Y_MAX);
    localparam logic [3:0] TRY_LIM  = 4'(MAX_TRIES);
    localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

    // Candidate must lie on the 10-pixel food grid inside the play area.
    function automatic logic cand_ok(input logic [9:0] x, input logic [9:0] y);
        logic in_x;
        logic in_y;
        logic on_grid;
        in_x    = (x >= X_LO) && (x <= X_HI);
        in_y    = (y >= Y_LO) && (y <= Y_HI);
        on_grid = ((x % 10'd10) == 10'd0) && ((y % 10'd10) == 10'd0);
        return in_x && in_y && on_grid;
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [9:0] cx_r;
    logic [9:0] cy_r;
    logic       cand_ok_r;
    logic [3:0] tries_r;
    logic [3:0] tries_s;
    logic [3:0] wait_r;
    logic       hit_s;

    assign occ_qx = cx_r;
    assign occ_qy = cy_r;

    // Next-state decode and hit resolution for the current query.
    always_comb begin
        state_s = state_r;
        hit_s   = 1'b0;
        tries_s = tries_r + 4'd1;
        case (state_r)
            IDLE: begin
                if (spawn_req) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = IDLE;
                end
            end
            SAMPLE: state_s = QUERY;
            QUERY: begin
                if (!cand_ok_r) begin
                    hit_s = 1'b1;
                end else if (occ_ack && occ_query) begin
                    if (occ_hit) begin
                        hit_s = 1'b1;
                    end else begin
                        state_s = COMMIT;
                    end
                end else if (wait_r == ACK_LAST) begin
                    hit_s = 1'b1;
                end else begin
                    hit_s = 1'b0;
                end
                if (hit_s) begin
                    if (tries_s < TRY_LIM) begin
                        state_s = SAMPLE;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    hit_s = 1'b0;
                end
            end
            COMMIT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge VGAclk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Candidate, counters and registered outputs.
    always_ff @(posedge VGAclk or posedge reset) begin
        if (reset) begin
            cx_r       <= 10'd0;
            cy_r       <= 10'd0;
            cand_ok_r  <= 1'b0;
            tries_r    <= 4'd0;
            wait_r     <= 4'd0;
            occ_query  <= 1'b0;
            busy       <= 1'b0;
            foodX      <= 10'd320;
            foodY      <= 10'd240;
            food_valid <= 1'b1;
            fail       <= 1'b0;
        end else begin
            busy <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (spawn_req) begin
                        food_valid <= 1'b0;
                        fail       <= 1'b0;
                        tries_r    <= 4'd0;
                    end
                end
                SAMPLE: begin
                    cx_r      <= rX;
                    cy_r      <= rY;
                    cand_ok_r <= cand_ok(rX, rY);
                    occ_query <= cand_ok(rX, rY);
                    wait_r    <= 4'd0;
                end
                QUERY: begin
                    wait_r <= wait_r + 4'd1;
                    if (state_s != QUERY) begin
                        occ_query <= 1'b0;
                    end
                    if (hit_s) begin
                        tries_r <= tries_s;
                        // Out of tries: keep the old position but mark it unplaced.
                        if (state_s == IDLE) begin
                            fail       <= 1'b1;
                            food_valid <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    foodX      <= cx_r;
                    foodY      <= cy_r;
                    food_valid <= 1'b1;
                end
                default: begin
                    occ_query <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// Directed self-checking bench for food_spawner with a simple occupancy responder.
module tb_food_spawner;

    logic       VGAclk;
    logic       reset;
    logic       spawn_req;
    logic [9:0] rX;
    logic [9:0] rY;
    logic       occ_query;
    logic [9:0] occ_qx;
    logic [9:0] occ_qy;
    logic       occ_ack;
    logic       occ_hit;
    logic [9:0] foodX;
    logic [9:0] foodY;
    logic       food_valid;
    logic       busy;
    logic       fail;

    int n_checks = 0;
    int n_errs   = 0;

    food_spawner #(
        .MAX_TRIES  (8),
        .ACK_TIMEOUT(15),
        .X_MIN      (20),
        .X_MAX      (620),
        .Y_MIN      (20),
        .Y_MAX      (460)
    ) dut (
        .VGAclk    (VGAclk),
        .reset     (reset),
        .spawn_req (spawn_req),
        .rX        (rX),
        .rY        (rY),
        .occ_query (occ_query),
        .occ_qx    (occ_qx),
        .occ_qy    (occ_qy),
        .occ_ack   (occ_ack),
        .occ_hit   (occ_hit),
        .foodX     (foodX),
        .foodY     (foodY),
        .food_valid(food_valid),
        .busy      (busy),
        .fail      (fail)
    );

    initial VGAclk = 1'b0;
    always #5 VGAclk = ~VGAclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge VGAclk);
        #1;
    endtask

    // One spawn: answers every query on its first cycle (if ack_en), with
    // hit=0 only on query number ok_on; rX advances by xstep per query seen.
    task automatic run_spawn(input bit ack_en, input int ok_on,
                             input logic [9:0] x0, input logic [9:0] xstep,
                             input logic [9:0] y0,
                             output int nq, output int cyc, output logic [9:0] last_qx);
        bit prev_q;
        int guard;
        nq      = 0;
        cyc     = 0;
        prev_q  = 1'b0;
        guard   = 0;
        last_qx = 10'd0;
        rX = x0;
        rY = y0;
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        cyc = 1;
        while (busy && guard < 400) begin
            occ_ack = 1'b0;
            occ_hit = 1'b0;
            if (occ_query && !prev_q) begin
                nq++;
                last_qx = occ_qx;
                rX = rX + xstep;
                if (ack_en) begin
                    occ_ack = 1'b1;
                    occ_hit = (nq != ok_on);
                end
            end
            prev_q = occ_query;
            tick();
            cyc++;
            guard++;
        end
        occ_ack = 1'b0;
        occ_hit = 1'b0;
        check("spawn_done_in_budget", 32'(guard < 400), 32'd1);
    endtask

    int         nq;
    int         cyc;
    logic [9:0] lqx;

    initial begin
        reset     = 1'b1;
        spawn_req = 1'b0;
        rX        = 10'd0;
        rY        = 10'd0;
        occ_ack   = 1'b0;
        occ_hit   = 1'b0;
        #2;
        check("rst_foodX", 32'(foodX), 32'd320);
        check("rst_foodY", 32'(foodY), 32'd240);
        check("rst_valid", 32'(food_valid), 32'd1);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_query", 32'(occ_query), 32'd0);
        check("rst_qxy", 32'({occ_qx, occ_qy}), 32'd0);
        repeat (2) @(posedge VGAclk);
        #1;
        reset = 1'b0;

        // Clean first-try spawn, minimum latency
        run_spawn(1'b1, 1, 10'd100, 10'd0, 10'd200, nq, cyc, lqx);
        check("t1_queries", 32'(nq), 32'd1);
        check("t1_qx", 32'(lqx), 32'd100);
        check("t1_latency", 32'(cyc), 32'd4);
        check("t1_foodX", 32'(foodX), 32'd100);
        check("t1_foodY", 32'(foodY), 32'd200);
        check("t1_valid", 32'(food_valid), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);

        // Two body hits then free at 90
        run_spawn(1'b1, 3, 10'd30, 10'd30, 10'd200, nq, cyc, lqx);
        check("t2_queries", 32'(nq), 32'd3);
        check("t2_cycles", 32'(cyc), 32'd8);
        check("t2_foodX", 32'(foodX), 32'd90);
        check("t2_fail", 32'(fail), 32'd0);
        check("t2_valid", 32'(food_valid), 32'd1);

        // Always occupied: exhaust 8 tries
        run_spawn(1'b1, 0, 10'd50, 10'd10, 10'd100, nq, cyc, lqx);
        check("t3_queries", 32'(nq), 32'd8);
        check("t3_cycles", 32'(cyc), 32'd17);
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_valid", 32'(food_valid), 32'd0);
        check("t3_foodX", 32'(foodX), 32'd90);
        check("t3_foodY", 32'(foodY), 32'd200);

        // No ack ever: each query times out after 15 cycles
        run_spawn(1'b0, 0, 10'd200, 10'd10, 10'd100, nq, cyc, lqx);
        check("t4_queries", 32'(nq), 32'd8);
        check("t4_cycles", 32'(cyc), 32'd129);
        check("t4_fail", 32'(fail), 32'd1);
        check("t4_foodX", 32'(foodX), 32'd90);

        // Out-of-range candidate, plus spawn_req held while busy
        rX = 10'd10;
        rY = 10'd100;
        spawn_req = 1'b1;
        tick();
        check("t5_busy_c1", 32'(busy), 32'd1);
        tick();
        check("t5_noquery", 32'(occ_query), 32'd0);
        check("t5_qx_c2", 32'(occ_qx), 32'd10);
        rX = 10'd40;
        tick();
        spawn_req = 1'b0;
        check("t5_retry_noquery", 32'(occ_query), 32'd0);
        tick();
        check("t5_query", 32'(occ_query), 32'd1);
        check("t5_qx", 32'(occ_qx), 32'd40);
        occ_ack = 1'b1;
        occ_hit = 1'b0;
        tick();
        occ_ack = 1'b0;
        check("t5_query_drop", 32'(occ_query), 32'd0);
        tick();
        check("t5_foodX", 32'(foodX), 32'd40);
        check("t5_valid", 32'(food_valid), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        tick();
        check("t5_no_requeue", 32'(busy), 32'd0);

        // Corner of the legal area is accepted
        run_spawn(1'b1, 1, 10'd620, 10'd0, 10'd460, nq, cyc, lqx);
        check("t6_foodX", 32'(foodX), 32'd620);
        check("t6_foodY", 32'(foodY), 32'd460);
        check("t6_fail", 32'(fail), 32'd0);

        // Off-grid candidate never queried, all tries fail
        run_spawn(1'b1, 1, 10'd105, 10'd0, 10'd100, nq, cyc, lqx);
        check("t7_queries", 32'(nq), 32'd0);
        check("t7_cycles", 32'(cyc), 32'd17);
        check("t7_fail", 32'(fail), 32'd1);
        check("t7_foodX", 32'(foodX), 32'd620);

        // Reset in the middle of a query
        rX = 10'd300;
        rY = 10'd300;
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        tick();
        check("t8_query", 32'(occ_query), 32'd1);
        reset = 1'b1;
        #1;
        check("t8_async_query", 32'(occ_query), 32'd0);
        check("t8_foodX", 32'(foodX), 32'd320);
        check("t8_foodY", 32'(foodY), 32'd240);
        check("t8_valid", 32'(food_valid), 32'd1);
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_fail", 32'(fail), 32'd0);
        #1;
        reset = 1'b0;
        rX = 10'd100;
        rY = 10'd100;
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        check("t8_accept_after_rst", 32'(busy), 32'd1);
        check("t8_valid_cleared", 32'(food_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
